// File: rtl/systolic_is_drain.sv
// systolic_is_drain: output-side collector for the input-stationary systolic
// array. Realigns the skewed bottom-edge column outputs into whole row
// vectors, buffers them in a small FIFO and hands them downstream on a
// valid/ready interface. Also keeps overflow and throughput counters.
module systolic_is_drain #(
  parameter int D_W   = 8,
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [N-1:0][2*D_W-1:0]           m2,
  input  logic                              clear,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N-1:0][2*D_W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]            fifo_level,
  output logic                              overflow,
  output logic [7:0]                        drop_count,
  output logic [15:0]                       vec_count
);

  localparam int W  = 2 * D_W;
  localparam int AW = $clog2(DEPTH);

  // Deskewed row: column j after it has travelled through its delay line.
  logic [N-1:0][W-1:0] row;
  // Tag pipe carrying in_valid alongside the data.
  logic [N-1:0]        tag;

  // FIFO storage and bookkeeping.
  logic [N-1:0][W-1:0] mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [AW:0]         count;
  logic                wr;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  // Column j arrives j cycles after column 0, so it needs N-j registers
  // (one capture plus N-1-j delay stages) to line up with the other columns.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int LEN = N - j;
    if (LEN == 1) begin : g_short
      logic [W-1:0] line;
      // Last column only needs its capture register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) line <= '0;
        else     line <= m2[j];
      end
      assign row[j] = line;
    end else begin : g_long
      logic [LEN-1:0][W-1:0] line;
      // Shift the column forward one stage per cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) line <= '0;
        else     line <= {line[LEN-2:0], m2[j]};
      end
      assign row[j] = line[LEN-1];
    end
  end

  // The tag pipe is as long as column 0's delay line, so its tail marks the
  // cycle in which a complete row sits at the delay-line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag <= '0;
    else     tag <= {tag[N-2:0], in_valid};
  end

  assign wr   = tag[N-1];
  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts the row if the head leaves in the same cycle.
  assign push = wr && (!full || pop);
  assign drop = wr && full && !pop;

  // FIFO storage needs no reset: out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= row;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Profiling counters; clear takes priority over any same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      vec_count  <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      vec_count  <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      if (pop) vec_count <= vec_count + 1'b1;
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rptr] : '0;
  assign fifo_level = count;

endmodule

// File: tb/tb_systolic_is_drain.sv
// Testbench for systolic_is_drain: cycle-level scoreboard model of the
// deskew + FIFO, a table of streaming scenarios, and hand-written sequences
// for the multi-cycle corner cases.
module tb_systolic_is_drain;

  localparam int D_W   = 8;
  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int W     = 2 * D_W;
  localparam int LMAX  = 1024;
  localparam int VMAX  = 512;

  typedef logic [N-1:0][W-1:0] vec_t;

  typedef struct {
    int n_vec;
    int gap;
    bit ready;
    int exp_level;
    bit exp_ovf;
    int exp_drop;
    int exp_vec;
  } scen_t;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  vec_t                  m2;
  logic                  clear;
  logic                  out_valid;
  logic                  out_ready;
  vec_t                  out_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                  overflow;
  logic [7:0]            drop_count;
  logic [15:0]           vec_count;

  systolic_is_drain #(.D_W(D_W), .N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .m2         (m2),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .vec_count  (vec_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   launch_at [LMAX];
  vec_t vec_tab [VMAX];
  int   n_vec = 0;
  int   mq [$];
  bit   m_ovf = 1'b0;
  int   m_drop = 0;
  logic [15:0] m_vec = '0;
  bit   ready_now = 1'b0;
  bit   clear_now = 1'b0;
  bit   junk_zero = 1'b0;
  scen_t tbl [5];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input int base);
    vec_t v;
    for (int j = 0; j < N; j++) v[j] = W'(base + j);
    return v;
  endfunction

  // Compare every output against the scoreboard model.
  task automatic checkOutput();
    vec_t exp_d;
    exp_d = (mq.size() > 0) ? vec_tab[mq[0]] : '0;
    check("out_valid",  128'(out_valid),  128'(mq.size() > 0));
    check("fifo_level", 128'(fifo_level), 128'(mq.size()));
    check("out_data",   128'(out_data),   128'(exp_d));
    check("overflow",   128'(overflow),   128'(m_ovf));
    check("drop_count", 128'(drop_count), 128'(m_drop));
    check("vec_count",  128'(vec_count),  128'(m_vec));
  endtask

  task automatic launch(input vec_t d);
    if (cyc >= LMAX || n_vec >= VMAX) begin
      $display("[TB] FAIL launch_bounds cycle %0d: got %0d expected below %0d", cyc, n_vec, VMAX);
      $fatal(1, "[TB] stimulus table exhausted");
    end
    launch_at[cyc] = n_vec;
    vec_tab[n_vec] = d;
    n_vec++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LMAX; i++) launch_at[i] = -1;
    n_vec = 0;
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    m_vec  = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // sample the DUT 1 time unit after the edge.
  task automatic applyStimulus();
    int id;
    int sz;
    int wid;
    bit do_pop;
    in_valid = (launch_at[cyc] >= 0);
    for (int j = 0; j < N; j++) begin
      id = (cyc - j >= 0) ? launch_at[cyc - j] : -1;
      if (id >= 0)        m2[j] = vec_tab[id][j];
      else if (junk_zero) m2[j] = '0;
      else                m2[j] = W'($urandom);
    end
    out_ready = ready_now;
    clear     = clear_now;
    sz     = mq.size();
    do_pop = (sz > 0) && ready_now;
    wid    = (cyc - N >= 0) ? launch_at[cyc - N] : -1;
    if (do_pop) begin
      void'(mq.pop_front());
      m_vec = m_vec + 16'd1;
    end
    if (wid >= 0) begin
      if (sz < DEPTH || do_pop) mq.push_back(wid);
      else begin
        m_ovf = 1'b1;
        if (m_drop != 255) m_drop++;
      end
    end
    if (clear_now) begin
      m_ovf  = 1'b0;
      m_drop = 0;
      m_vec  = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    m2        = '0;
    ready_now = 1'b0;
    clear_now = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4, 1, 1'b1, 0, 1'b0, 0, 4};
    tbl[1] = '{6, 1, 1'b0, 4, 1'b1, 2, 0};
    tbl[2] = '{3, 3, 1'b0, 3, 1'b0, 0, 0};
    tbl[3] = '{8, 1, 1'b0, 4, 1'b1, 4, 0};
    tbl[4] = '{5, 2, 1'b1, 0, 1'b0, 0, 5};

    // Single vector, zeros elsewhere, latency N then one pop.
    do_reset();
    junk_zero = 1'b1;
    ready_now = 1'b1;
    launch(mk(1));
    repeat (N) applyStimulus();
    check("t1_not_yet_valid", 128'(out_valid), 128'(0));
    applyStimulus();
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_data", 128'(out_data), 128'(mk(1)));
    applyStimulus();
    check("t1_vec_count", 128'(vec_count), 128'(1));
    junk_zero = 1'b0;

    // Streaming scenarios with fixed end-state expectations.
    for (int s = 0; s < 5; s++) begin
      do_reset();
      ready_now = tbl[s].ready;
      for (int v = 0; v < tbl[s].n_vec; v++) begin
        launch(mk(16 * v));
        applyStimulus();
        repeat (tbl[s].gap - 1) applyStimulus();
      end
      repeat (N + 3) applyStimulus();
      check($sformatf("scen%0d_level", s), 128'(fifo_level), 128'(tbl[s].exp_level));
      check($sformatf("scen%0d_ovf", s),   128'(overflow),   128'(tbl[s].exp_ovf));
      check($sformatf("scen%0d_drop", s),  128'(drop_count), 128'(tbl[s].exp_drop));
      check($sformatf("scen%0d_vec", s),   128'(vec_count),  128'(tbl[s].exp_vec));
    end

    // Overflow with 6 vectors, then clear, then drain with a clear on a pop.
    do_reset();
    for (int v = 0; v < 6; v++) begin
      launch(mk(16 * v));
      applyStimulus();
    end
    repeat (N + 3) applyStimulus();
    check("t3_level", 128'(fifo_level), 128'(4));
    check("t3_ovf", 128'(overflow), 128'(1));
    check("t3_drop", 128'(drop_count), 128'(2));
    check("t3_head", 128'(out_data), 128'(mk(0)));
    clear_now = 1'b1;
    applyStimulus();
    clear_now = 1'b0;
    check("t6_ovf", 128'(overflow), 128'(0));
    check("t6_drop", 128'(drop_count), 128'(0));
    check("t6_vec", 128'(vec_count), 128'(0));
    check("t6_level", 128'(fifo_level), 128'(4));
    check("t6_head", 128'(out_data), 128'(mk(0)));
    ready_now = 1'b1;
    repeat (2) applyStimulus();
    clear_now = 1'b1;
    applyStimulus();
    clear_now = 1'b0;
    check("clear_pop_vec", 128'(vec_count), 128'(0));
    check("clear_pop_level", 128'(fifo_level), 128'(1));
    check("drain_last", 128'(out_data), 128'(mk(48)));
    repeat (2) applyStimulus();

    // Full FIFO with a write and a pop on the same edge.
    do_reset();
    for (int v = 0; v < 5; v++) begin
      launch(mk(16 * v));
      applyStimulus();
    end
    repeat (7) applyStimulus();
    check("t4_full", 128'(fifo_level), 128'(4));
    ready_now = 1'b1;
    applyStimulus();
    ready_now = 1'b0;
    check("t4_level", 128'(fifo_level), 128'(4));
    check("t4_ovf", 128'(overflow), 128'(0));
    check("t4_drop", 128'(drop_count), 128'(0));
    check("t4_head", 128'(out_data), 128'(mk(16)));
    ready_now = 1'b1;
    repeat (5) applyStimulus();

    // Asynchronous reset with a vector in flight and a non-empty FIFO.
    do_reset();
    launch(mk(100));
    applyStimulus();
    launch(mk(200));
    applyStimulus();
    repeat (N) applyStimulus();
    ready_now = 1'b1;
    applyStimulus();
    ready_now = 1'b0;
    check("t5_pre_level", 128'(fifo_level), 128'(1));
    launch(mk(300));
    repeat (3) applyStimulus();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("t5_valid", 128'(out_valid), 128'(0));
    check("t5_level", 128'(fifo_level), 128'(0));
    check("t5_data", 128'(out_data), 128'(0));
    check("t5_vec", 128'(vec_count), 128'(0));
    #1;
    rst = 1'b0;
    ready_now = 1'b1;
    launch(mk(400));
    repeat (N) applyStimulus();
    check("t5_not_yet_valid", 128'(out_valid), 128'(0));
    applyStimulus();
    check("t5_after_valid", 128'(out_valid), 128'(1));
    check("t5_after_data", 128'(out_data), 128'(mk(400)));
    repeat (3) applyStimulus();

    // Drop counter saturation.
    do_reset();
    for (int v = 0; v < 262; v++) begin
      launch(mk(16 * v));
      applyStimulus();
    end
    repeat (N + 2) applyStimulus();
    check("sat_drop", 128'(drop_count), 128'(255));
    check("sat_ovf", 128'(overflow), 128'(1));
    check("sat_head", 128'(out_data), 128'(mk(0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
